// File: rtl/cc_cond_unit.sv
// Y86-64 condition-code register and jXX/cmovXX condition evaluator.
// Latches ALU flags on OPq and produces a registered, one-cycle-latency cnd.
module cc_cond_unit #(
  parameter int   CNT_W  = 16,
  parameter logic RST_ZF = 1'b1,
  parameter logic RST_SF = 1'b0,
  parameter logic RST_OF = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_cc,
  input  logic             zf_in,
  input  logic             sf_in,
  input  logic             of_in,
  input  logic             stall,
  input  logic             cond_req,
  input  logic [3:0]       ifun,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd,
  output logic             cnd_valid,
  output logic             cond_err,
  output logic [CNT_W-1:0] cc_upd_cnt
);

  typedef enum logic [3:0] {
    C_ALWAYS = 4'd0,
    C_LE     = 4'd1,
    C_L      = 4'd2,
    C_E      = 4'd3,
    C_NE     = 4'd4,
    C_GE     = 4'd5,
    C_G      = 4'd6
  } cond_e;

  logic             r_zf, r_sf, r_of;
  logic             r_cnd, r_cnd_valid, r_cond_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_x;
  logic w_cnd;
  logic w_illegal;

  // Evaluated against the stored CC, so a same-cycle set_cc never feeds
  // its own flags into the condition.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    w_cnd     = 1'b0;
    w_illegal = 1'b0;
    w_x       = r_sf ^ r_of;
    case (ifun)
      C_ALWAYS: w_cnd = 1'b1;
      C_LE:     w_cnd = w_x | r_zf;
      C_L:      w_cnd = w_x;
      C_E:      w_cnd = r_zf;
      C_NE:     w_cnd = ~r_zf;
      C_GE:     w_cnd = ~w_x;
      C_G:      w_cnd = ~w_x & ~r_zf;
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_zf        <= RST_ZF;
      r_sf        <= RST_SF;
      r_of        <= RST_OF;
      r_cnd       <= 1'b0;
      r_cnd_valid <= 1'b0;
      r_cond_err  <= 1'b0;
      r_cnt       <= '0;
    end else if (stall) begin
      r_cnd_valid <= 1'b0;
    end else begin
      if (set_cc) begin
        r_zf  <= zf_in;
        r_sf  <= sf_in;
        r_of  <= of_in;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_cnd_valid <= cond_req;
      if (cond_req) begin
        r_cnd      <= w_cnd;
        r_cond_err <= w_illegal;
      end
    end
  end

  assign zf         = r_zf;
  assign sf         = r_sf;
  assign of         = r_of;
  assign cnd        = r_cnd;
  assign cnd_valid  = r_cnd_valid;
  assign cond_err   = r_cond_err;
  assign cc_upd_cnt = r_cnt;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed bench for cc_cond_unit: expected cnd/cond_err results are queued
// when a request is driven and popped when the unit reports cnd_valid.
module tb_cc_cond_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_cc, zf_in, sf_in, of_in, stall, cond_req;
  logic [3:0]  ifun;
  logic        zf, sf, of, cnd, cnd_valid, cond_err;
  logic [15:0] cc_upd_cnt;

  cc_cond_unit #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_cc     (set_cc),
    .zf_in      (zf_in),
    .sf_in      (sf_in),
    .of_in      (of_in),
    .stall      (stall),
    .cond_req   (cond_req),
    .ifun       (ifun),
    .zf         (zf),
    .sf         (sf),
    .of         (of),
    .cnd        (cnd),
    .cnd_valid  (cnd_valid),
    .cond_err   (cond_err),
    .cc_upd_cnt (cc_upd_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cnd;
    logic err;
  } exp_t;

  exp_t        q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  logic        m_zf, m_sf, m_of, m_cnd, m_err;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".zf"}, zf, m_zf);
    chk({tag, ".sf"}, sf, m_sf);
    chk({tag, ".of"}, of, m_of);
    chk({tag, ".cnt"}, cc_upd_cnt, m_cnt);
  endtask

  // One clock: inputs applied 1 time unit after an edge, outputs sampled
  // 1 time unit after the next edge. flags = {zf, sf, of}.
  task automatic cyc(input string tag, input logic sc, input logic [2:0] flags,
                     input logic cr, input logic [3:0] fn, input logic st,
                     input logic ecnd, input logic eerr);
    exp_t e;
    set_cc   = sc;
    {zf_in, sf_in, of_in} = flags;
    cond_req = cr;
    ifun     = fn;
    stall    = st;
    if (cr && !st) begin
      e.cnd = ecnd;
      e.err = eerr;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sc && !st) begin
      {m_zf, m_sf, m_of} = flags;
      m_cnt = m_cnt + 16'd1;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      m_cnd = e.cnd;
      m_err = e.err;
      chk({tag, ".valid"}, cnd_valid, 1'b1);
    end else begin
      chk({tag, ".valid"}, cnd_valid, 1'b0);
    end
    chk({tag, ".cnd"}, cnd, m_cnd);
    chk({tag, ".err"}, cond_err, m_err);
    chk_state(tag);
    set_cc = 1'b0; cond_req = 1'b0; stall = 1'b0; ifun = 4'd0;
  endtask

  task automatic model_reset();
    q.delete();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    m_cnd = 1'b0; m_err = 1'b0; m_cnt = 16'd0;
  endtask

  initial begin
    rst = 1'b1;
    set_cc = 1'b0; zf_in = 1'b0; sf_in = 1'b0; of_in = 1'b0;
    stall = 1'b0; cond_req = 1'b0; ifun = 4'd0;
    model_reset();
    #1;
    chk("por.cnd", cnd, 1'b0);
    chk("por.valid", cnd_valid, 1'b0);
    chk_state("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Some activity, then an async reset between edges with a request in flight.
    cyc("pre", 1'b1, 3'b011, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    cond_req = 1'b1; ifun = 4'd0; set_cc = 1'b1; {zf_in, sf_in, of_in} = 3'b000;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst.cnd", cnd, 1'b0);
    chk("arst.valid", cnd_valid, 1'b0);
    chk("arst.err", cond_err, 1'b0);
    chk_state("arst");
    @(posedge clk); #1;
    chk("arst_hold.valid", cnd_valid, 1'b0);
    chk_state("arst_hold");
    rst = 1'b0; cond_req = 1'b0; set_cc = 1'b0;

    cyc("rst_e", 1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);

    // 3 + (-4) = -1 : ZF=0 SF=1 OF=0
    cyc("neg.set", 1'b1, 3'b010, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("neg.l",   1'b0, 3'b000, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
    cyc("neg.ge",  1'b0, 3'b000, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
    cyc("neg.g",   1'b0, 3'b000, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    chk("neg.cnt1", cc_upd_cnt, 16'd1);

    // Equal operands subtracted: ZF=1 SF=0 OF=0
    cyc("eq.set",  1'b1, 3'b100, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("eq.e",    1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    cyc("eq.ne",   1'b0, 3'b000, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    cyc("eq.le",   1'b0, 3'b000, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);

    // 0x7FFF...F + 1 : ZF=0 SF=1 OF=1
    cyc("ovf.set", 1'b1, 3'b011, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("ovf.l",   1'b0, 3'b000, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc("ovf.ge",  1'b0, 3'b000, 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
    cyc("ovf.g",   1'b0, 3'b000, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
    cyc("ovf.le",  1'b0, 3'b000, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);

    // cnd holds while no request; flag inputs ignored (even X) without set_cc.
    cyc("idle",    1'b0, 3'bxxx, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Same-cycle set_cc + request uses the old flags.
    cyc("same.pre", 1'b1, 3'b100, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("same.e",   1'b1, 3'b000, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    cyc("same.nxt", 1'b0, 3'b000, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);

    // Stall drops both the update and the request.
    cyc("stall.a",  1'b0, 3'b000, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc("stall",    1'b1, 3'b111, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
    cyc("stall.b",  1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Illegal codes 7..15, error holds on idle cycles, cleared by a legal request.
    for (int f = 7; f < 16; f++)
      cyc("illegal", 1'b0, 3'b000, 1'b1, 4'(f), 1'b0, 1'b0, 1'b1);
    cyc("err.hold",   1'b0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc("err.stall",  1'b0, 3'b000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc("err.clr",    1'b0, 3'b000, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);

    // Drive the update counter to 0xFFFF, then one more update wraps to 0.
    while (m_cnt != 16'hFFFF)
      cyc("fill", 1'b1, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("cnt.max", cc_upd_cnt, 16'hFFFF);
    cyc("wrap", 1'b1, 3'b001, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("cnt.wrap", cc_upd_cnt, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cc_cond_unit.md
Name: cc_cond_unit

Overview:
Consumer end of the ALU flag interface in the SEQ Execute stage. It latches Zero_flag, Sign_flag and Overflow_flag from alu_64bit into the architectural condition-code register (CC) when the current instruction is OPq. It evaluates the Y86-64 jXX/cmovXX condition named by ifun against the stored CC. The result is a registered cnd, used by PC-select and by the destination-register write enable.

Parameters:
CNT_W, 16, width of the CC-update event counter (debug/perf).
RST_ZF, 1, ZF value after reset.
RST_SF, 0, SF value after reset.
RST_OF, 0, OF value after reset.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
set_cc  input  1  update CC from the flag inputs this cycle (OPq).
zf_in  input  1  ALU Zero_flag.
sf_in  input  1  ALU Sign_flag.
of_in  input  1  ALU Overflow_flag.
stall  input  1  freeze all state; highest priority after rst.
cond_req  input  1  condition evaluation request (jXX/cmovXX valid).
ifun  input  4  condition code function field.
zf  output  1  stored ZF.
sf  output  1  stored SF.
of  output  1  stored OF.
cnd  output  1  registered condition result.
cnd_valid  output  1  cnd corresponds to the request from the previous cycle.
cond_err  output  1  previous request had an illegal ifun.
cc_upd_cnt  output  CNT_W  number of accepted CC updates.

Behaviour:
- Reset (async, rst=1): zf/sf/of = RST_ZF/RST_SF/RST_OF (1/0/0). cnd=0, cnd_valid=0, cond_err=0, cc_upd_cnt=0. Reset asserted mid-operation discards any in-flight request immediately.
- Priority at each posedge: rst > stall > normal operation.
- stall=1: CC, cnd, cond_err, cc_upd_cnt hold; cnd_valid forced to 0; set_cc and cond_req are dropped, not queued.
- CC update: at posedge with set_cc=1 and stall=0, {zf,sf,of} <= {zf_in,sf_in,of_in}, and cc_upd_cnt increments, wrapping from 2^CNT_W-1 to 0. With set_cc=0, CC holds.
- Condition evaluation, 1-cycle latency: at posedge with cond_req=1 and stall=0, the unit computes from the CC value held before this edge (pre-update), then sets cnd_valid=1. With cond_req=0, cnd_valid=0 and cnd holds its last value.
- ifun decode (X = SF^OF):
  - 0 always: cnd=1
  - 1 le: cnd = X|ZF
  - 2 l: cnd = X
  - 3 e: cnd = ZF
  - 4 ne: cnd = ~ZF
  - 5 ge: cnd = ~X
  - 6 g: cnd = ~X & ~ZF
  - 7..15: cnd=0, cond_err=1
- cond_err is set only on a request cycle. It is cleared on any legal request and holds otherwise.
- Simultaneous set_cc and cond_req in one cycle: evaluation uses the old flags, and the CC updates on the same edge. The next request sees the new flags. This matches SEQ semantics: an OPq never conditions itself.
- Flag inputs are sampled only when set_cc=1; X/Z on them at other times has no effect.

Test Plan:
- Reset check: assert rst asynchronously between edges -> outputs immediately zf=1, sf=0, of=0, cnd=0, cnd_valid=0, cc_upd_cnt=0. Then cond_req with ifun=3 (e) -> next cycle cnd=1, cnd_valid=1.
- Add 3 + (-4) = -1 (ZF=0, SF=1, OF=0) with set_cc; next cycle cond_req ifun=2 (l) -> cnd=1. ifun=5 (ge) -> cnd=0. ifun=6 (g) -> cnd=0. cc_upd_cnt=1.
- Subtract equal operands 0xCCCC_CCCC_CCCC_CCCC (ZF=1, SF=0, OF=0) with set_cc -> ifun=3 gives cnd=1, ifun=4 gives cnd=0, ifun=1 (le) gives cnd=1.
- Overflow case: 0x7FFF_FFFF_FFFF_FFFF + 1 (ZF=0, SF=1, OF=1) -> ifun=2 gives cnd=0, ifun=5 gives cnd=1, ifun=6 gives cnd=1.
- Same-cycle set_cc and cond_req: CC holds ZF=1; apply set_cc with ZF=0 together with ifun=3 -> cnd=1 (old flags). A following ifun=3 request -> cnd=0.
- Stall and illegal ifun: stall=1 with set_cc=1 and cond_req=1 -> CC and cc_upd_cnt unchanged, cnd_valid=0. ifun=9 -> cnd=0, cond_err=1. Next ifun=0 -> cnd=1, cond_err=0. Preloading cc_upd_cnt to 0xFFFF and issuing one update -> wraps to 0.
